// File: rtl/scarv_integ_pkg.sv
// Shared constants for the PicoRV32 PCPI to XCrypto COP integration:
// COP result codes, RISC-V custom opcodes and the bridge state encoding.
package scarv_integ_pkg;

  localparam logic [2:0] RES_ILLEGAL = 3'b010;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
  localparam logic [6:0] OPC_CUSTOM2 = 7'b1011011;
  localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_EXEC  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/scarv_integ_prv_pcpi2cop_seq.sv
// Registered PCPI to COP bridge: filters custom opcodes, issues the captured
// instruction with a req/ack handshake and returns the registered response.
module scarv_integ_prv_pcpi2cop_seq
  import scarv_integ_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8,
  parameter logic [3:0]  OPC_EN  = 4'b1111
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        cpu_insn_req,
  input  logic        cop_insn_ack,
  output logic [31:0] cpu_insn_enc,
  output logic [31:0] cpu_rs1,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  input  logic [2:0]  cop_result,
  input  logic        cop_insn_rsp,
  output logic        cpu_insn_ack,
  output logic        stat_timeout,
  output logic        stat_illegal
);

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic             TMO_EN = (TIMEOUT != 0);

  function automatic logic opc_hit(input logic [6:0] opc);
    case (opc)
      OPC_CUSTOM0: opc_hit = OPC_EN[0];
      OPC_CUSTOM1: opc_hit = OPC_EN[1];
      OPC_CUSTOM2: opc_hit = OPC_EN[2];
      OPC_CUSTOM3: opc_hit = OPC_EN[3];
      default:     opc_hit = 1'b0;
    endcase
  endfunction

  state_t            state, state_d;
  logic [31:0]       enc_q, enc_d;
  logic [31:0]       rs1_q, rs1_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [31:0]       rd_q, rd_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              drain_seen, drain_seen_d;
  logic              issue_abort, issue_abort_d;
  logic              unused_ok;

  assign unused_ok = ^{pcpi_rs2, cop_waddr};

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state       <= ST_IDLE;
      enc_q       <= '0;
      rs1_q       <= '0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      ready_q     <= 1'b0;
      cnt         <= '0;
      drain_seen  <= 1'b0;
      issue_abort <= 1'b0;
    end else begin
      state       <= state_d;
      enc_q       <= enc_d;
      rs1_q       <= rs1_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ready_q     <= ready_d;
      cnt         <= cnt_d;
      drain_seen  <= drain_seen_d;
      issue_abort <= issue_abort_d;
    end
  end

  always_comb begin
    state_d       = state;
    enc_d         = enc_q;
    rs1_d         = rs1_q;
    req_d         = req_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    ready_d       = 1'b0;
    cnt_d         = cnt;
    drain_seen_d  = drain_seen;
    issue_abort_d = issue_abort;
    stat_timeout  = 1'b0;
    stat_illegal  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pcpi_valid && opc_hit(pcpi_insn[6:0])) begin
          enc_d         = pcpi_insn;
          rs1_d         = pcpi_rs1;
          req_d         = 1'b1;
          issue_abort_d = 1'b0;
          state_d       = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A valid drop while waiting for ack is remembered so that a later
        // re-assertion of valid cannot revive the abandoned instruction.
        if (!pcpi_valid) issue_abort_d = 1'b1;
        if (cop_insn_ack) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (issue_abort || !pcpi_valid) begin
            drain_seen_d = 1'b0;
            state_d      = ST_DRAIN;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (cop_insn_rsp) begin
          if (cop_result == RES_ILLEGAL) begin
            stat_illegal = 1'b1;
            drain_seen_d = 1'b1;
            state_d      = ST_DRAIN;
          end else if (!pcpi_valid) begin
            drain_seen_d = 1'b1;
            state_d      = ST_DRAIN;
          end else begin
            wr_d    = cop_wen;
            rd_d    = cop_wdata;
            ready_d = 1'b1;
            state_d = ST_RESP;
          end
        end else if (!pcpi_valid) begin
          drain_seen_d = 1'b0;
          state_d      = ST_DRAIN;
        end else if (TMO_EN && (cnt == TMO)) begin
          stat_timeout = 1'b1;
          drain_seen_d = 1'b0;
          state_d      = ST_DRAIN;
        end else if (cnt != TMO) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (!pcpi_valid) begin
          wr_d    = 1'b0;
          rd_d    = '0;
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (cop_insn_rsp) drain_seen_d = 1'b1;
        if ((drain_seen || cop_insn_rsp) && !pcpi_valid) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pcpi_wait    = pcpi_valid && opc_hit(pcpi_insn[6:0]) &&
                        ((state == ST_IDLE) || (state == ST_ISSUE) || (state == ST_EXEC));
  assign cpu_insn_ack = (state == ST_EXEC) || (state == ST_DRAIN);
  assign cpu_insn_req = req_q;
  assign cpu_insn_enc = enc_q;
  assign cpu_rs1      = rs1_q;
  assign pcpi_wr      = wr_q;
  assign pcpi_rd      = rd_q;
  assign pcpi_ready   = ready_q;

endmodule

// File: tb/tb_scarv_integ_prv_pcpi2cop_seq.sv
// Bench for the PCPI to COP bridge: directed vector table, reset-in-ISSUE
// sequence and random transactions against a transaction-level model.
module tb_scarv_integ_prv_pcpi2cop_seq;

  localparam int unsigned T  = 4;
  localparam logic [3:0]  EN = 4'b1101;

  logic        g_clk, g_reset;
  logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;
  logic        cpu_insn_req, cop_insn_ack, cop_wen, cop_insn_rsp, cpu_insn_ack;
  logic [31:0] cpu_insn_enc, cpu_rs1, cop_wdata;
  logic [4:0]  cop_waddr;
  logic [2:0]  cop_result;
  logic        stat_timeout, stat_illegal;

  scarv_integ_prv_pcpi2cop_seq #(.TIMEOUT(T), .CNT_W(8), .OPC_EN(EN)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
    .cop_result(cop_result), .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
    .stat_timeout(stat_timeout), .stat_illegal(stat_illegal)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    int          ack_dly;   // cycles of req before ack
    int          rsp_dly;   // EXEC cycle index of the response
    int          abort_at;  // EXEC cycle index where valid drops, -1 = never
    logic        wen;
    logic [31:0] wdata;
    logic [2:0]  result;
    logic        exp_hit;
    int          exp_ready;
    int          exp_ill;
    int          exp_to;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] insn, input logic [31:0] rs1,
                              input int ack, input int rsp, input int ab,
                              input logic wen, input logic [31:0] wdata, input logic [2:0] res,
                              input logic hit, input int rdy, input int ill, input int to);
    vec_t v;
    v.insn = insn; v.rs1 = rs1; v.ack_dly = ack; v.rsp_dly = rsp; v.abort_at = ab;
    v.wen = wen; v.wdata = wdata; v.result = res;
    v.exp_hit = hit; v.exp_ready = rdy; v.exp_ill = ill; v.exp_to = to;
    return v;
  endfunction

  // Transaction-level reference: which of response, abort or timeout
  // decides the instruction, from the cycle indices alone.
  function automatic void predict(inout vec_t v);
    logic [6:0] opc;
    int a, r;
    opc = v.insn[6:0];
    v.exp_hit = (opc == 7'h0B && EN[0]) || (opc == 7'h2B && EN[1]) ||
                (opc == 7'h5B && EN[2]) || (opc == 7'h7B && EN[3]);
    v.exp_ready = 0; v.exp_ill = 0; v.exp_to = 0;
    if (!v.exp_hit) return;
    a = (v.abort_at < 0) ? 1000 : v.abort_at;
    r = v.rsp_dly;
    if (r <= int'(T) && r <= a) begin
      v.exp_ill   = (v.result == 3'b010) ? 1 : 0;
      v.exp_ready = (v.result != 3'b010 && r < a) ? 1 : 0;
    end else if (a > int'(T)) begin
      v.exp_to = 1;
    end
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    int rsp_cyc, ab_cyc, drop_cyc, ready_cyc, to_cyc, ill_cyc, n_ready, n_ill, n_to;
    bit dropped, react, done;
    logic wr_seen;
    logic [31:0] rd_seen;
    rsp_cyc = 2 + v.ack_dly + v.rsp_dly;
    ab_cyc  = (v.abort_at < 0) ? -1 : 2 + v.ack_dly + v.abort_at;
    drop_cyc = -1; ready_cyc = -1; to_cyc = -1; ill_cyc = -1;
    n_ready = 0; n_ill = 0; n_to = 0;
    dropped = 0; react = 0; done = 0;
    wr_seen = 1'b0; rd_seen = '0;
    if (!v.exp_hit) begin
      for (int c = 0; c < 6; c++) begin
        @(posedge g_clk); #1;
        pcpi_valid = 1'b1; pcpi_insn = v.insn; pcpi_rs1 = v.rs1; pcpi_rs2 = $urandom;
        cop_insn_ack = 1'b0; cop_insn_rsp = 1'b0;
        @(negedge g_clk);
        chk({tag, " filt_req"}, 32'(cpu_insn_req), 32'd0);
        chk({tag, " filt_wait"}, 32'(pcpi_wait), 32'd0);
      end
    end else begin
      for (int c = 0; c < 80 && !done; c++) begin
        @(posedge g_clk); #1;
        if (!dropped && (react || c == ab_cyc)) begin
          dropped = 1; drop_cyc = c;
        end
        pcpi_valid   = !dropped;
        pcpi_insn    = v.insn;
        pcpi_rs1     = v.rs1;
        pcpi_rs2     = $urandom;
        cop_insn_ack = (c == 1 + v.ack_dly);
        cop_insn_rsp = (c == rsp_cyc);
        cop_wen      = cop_insn_rsp ? v.wen : 1'($urandom);
        cop_wdata    = cop_insn_rsp ? v.wdata : $urandom;
        cop_result   = cop_insn_rsp ? v.result : 3'($urandom);
        cop_waddr    = 5'($urandom);
        @(negedge g_clk);
        chk({tag, " req"}, 32'(cpu_insn_req), 32'(c >= 1 && c <= 1 + v.ack_dly));
        if (c == 0) chk({tag, " wait_idle"}, 32'(pcpi_wait), 32'd1);
        if (c == 1) begin
          chk({tag, " enc"}, cpu_insn_enc, v.insn);
          chk({tag, " rs1"}, cpu_rs1, v.rs1);
        end
        if (c == rsp_cyc) chk({tag, " cop_ack"}, 32'(cpu_insn_ack), 32'd1);
        if (pcpi_ready) begin
          n_ready++; ready_cyc = c; wr_seen = pcpi_wr; rd_seen = pcpi_rd;
        end
        if (stat_illegal) begin n_ill++; ill_cyc = c; end
        if (stat_timeout) begin n_to++; to_cyc = c; end
        if (pcpi_valid && ((ill_cyc >= 0 && c == ill_cyc + 1) || (to_cyc >= 0 && c == to_cyc + 1)))
          chk({tag, " wait_drop"}, 32'(pcpi_wait), 32'd0);
        if (pcpi_ready || (c > 0 && !pcpi_wait)) react = 1;
        done = dropped && (c >= rsp_cyc) && (c >= drop_cyc);
      end
      if (!done) begin
        checks++; failures++;
        $display("FAIL %s bound: transaction did not complete in 80 cycles", tag);
      end
      chk({tag, " n_ready"}, 32'(n_ready), 32'(v.exp_ready));
      chk({tag, " n_illegal"}, 32'(n_ill), 32'(v.exp_ill));
      chk({tag, " n_timeout"}, 32'(n_to), 32'(v.exp_to));
      if (v.exp_ready != 0) begin
        chk({tag, " latency"}, 32'(ready_cyc), 32'(3 + v.ack_dly + v.rsp_dly));
        chk({tag, " wr"}, 32'(wr_seen), 32'(v.wen));
        chk({tag, " rd"}, rd_seen, v.wdata);
      end
      if (v.exp_to != 0) chk({tag, " to_cycle"}, 32'(to_cyc), 32'(2 + v.ack_dly + int'(T)));
    end
    @(posedge g_clk); #1;
    pcpi_valid = 1'b0; cop_insn_ack = 1'b0; cop_insn_rsp = 1'b0;
    @(negedge g_clk);
    chk({tag, " post_wr"}, 32'(pcpi_wr), 32'd0);
    chk({tag, " post_rd"}, pcpi_rd, 32'd0);
    chk({tag, " post_ready"}, 32'(pcpi_ready), 32'd0);
    chk({tag, " post_req"}, 32'(cpu_insn_req), 32'd0);
  endtask

  vec_t tbl[9];
  logic [6:0] opcs[5];

  initial begin
    tbl[0] = mk(32'h0000000B, 32'hDEADBEEF, 2, 3, -1, 1'b1, 32'h12345678, 3'd0, 1'b1, 1, 0, 0);
    tbl[1] = mk(32'h0000002B, 32'h11111111, 0, 0, -1, 1'b1, 32'h0,        3'd0, 1'b0, 0, 0, 0);
    tbl[2] = mk(32'h00B50533, 32'h22222222, 0, 0, -1, 1'b1, 32'h0,        3'd0, 1'b0, 0, 0, 0);
    tbl[3] = mk(32'h1234505B, 32'h33333333, 0, 1, -1, 1'b1, 32'hAAAA5555, 3'd2, 1'b1, 0, 1, 0);
    tbl[4] = mk(32'h0000007B, 32'h44444444, 0, 7, -1, 1'b1, 32'h55555555, 3'd0, 1'b1, 0, 0, 1);
    tbl[5] = mk(32'hABCDE00B, 32'h55555555, 1, 3,  1, 1'b1, 32'h66666666, 3'd0, 1'b1, 0, 0, 0);
    tbl[6] = mk(32'h0000107B, 32'h66666666, 0, 4, -1, 1'b0, 32'hCAFEF00D, 3'd1, 1'b1, 1, 0, 0);
    tbl[7] = mk(32'h0000200B, 32'h77777777, 0, 2,  2, 1'b1, 32'h88888888, 3'd0, 1'b1, 0, 0, 0);
    tbl[8] = mk(32'h0000305B, 32'h88888888, 0, 0, -1, 1'b1, 32'hFFFFFFFF, 3'd3, 1'b1, 1, 0, 0);
    opcs[0] = 7'h0B; opcs[1] = 7'h2B; opcs[2] = 7'h5B; opcs[3] = 7'h7B; opcs[4] = 7'h33;

    g_reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    cop_insn_ack = 1'b0; cop_wen = 1'b0; cop_waddr = '0; cop_wdata = '0;
    cop_result = '0; cop_insn_rsp = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_req", 32'(cpu_insn_req), 32'd0);
    chk("rst_ready", 32'(pcpi_ready), 32'd0);
    chk("rst_wr", 32'(pcpi_wr), 32'd0);
    chk("rst_rd", pcpi_rd, 32'd0);
    chk("rst_enc", cpu_insn_enc, 32'd0);
    chk("rst_rs1", cpu_rs1, 32'd0);
    chk("rst_wait", 32'(pcpi_wait), 32'd0);
    chk("rst_cop_ack", 32'(cpu_insn_ack), 32'd0);
    chk("rst_stats", 32'({stat_timeout, stat_illegal}), 32'd0);
    @(posedge g_clk); #1 g_reset = 1'b0;

    for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset while the request is outstanding in ISSUE.
    @(posedge g_clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = 32'h0000407B; pcpi_rs1 = 32'h0BADF00D;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("rstiss_req_before", 32'(cpu_insn_req), 32'd1);
    g_reset = 1'b1; pcpi_valid = 1'b0;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("rstiss_req", 32'(cpu_insn_req), 32'd0);
    chk("rstiss_enc", cpu_insn_enc, 32'd0);
    chk("rstiss_cop_ack", 32'(cpu_insn_ack), 32'd0);
    g_reset = 1'b0;
    run_txn("after_rst", tbl[0]);

    for (int i = 0; i < 150; i++) begin
      vec_t v;
      v.insn     = {25'($urandom), opcs[$urandom_range(4, 0)]};
      v.rs1      = $urandom;
      v.ack_dly  = $urandom_range(3, 0);
      v.rsp_dly  = $urandom_range(8, 0);
      v.abort_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
      v.wen      = 1'($urandom);
      v.wdata    = $urandom;
      if ($urandom_range(3, 0) == 0) v.result = 3'b010;
      else begin
        v.result = 3'($urandom_range(7, 0));
        if (v.result == 3'b010) v.result = 3'b000;
      end
      predict(v);
      run_txn($sformatf("rnd%0d", i), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scarv_integ_prv_pcpi2cop_seq.md
# scarv_integ_prv_pcpi2cop_seq

Registered, state-machine-driven bridge between the PicoRV32 Pico Co-Processor Interface (PCPI) and the XCrypto COP instruction interface. It sits in the PicoRV32 integration between the CPU's PCPI port and the XCrypto co-processor. It adds the following on top of the PicoRV32-to-COP glue:

- opcode filtering;
- registered request capture with a full req/ack handshake;
- response registering;
- abort handling when `pcpi_valid` drops mid-instruction;
- a configurable execution timeout;
- status pulses for integration counters.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent in EXEC before abort. 0 disables the timeout.
- `CNT_W`, default 8: timeout counter width. Requires `TIMEOUT < 2**CNT_W`.
- `OPC_EN`, default 4'b1111: per-bit enable for custom-0..3 opcodes (7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011).

Ports:
- `g_clk` in 1: clock, all state on the rising edge.
- `g_reset` in 1: synchronous, active-high reset.
- `pcpi_valid` in 1: PCPI instruction valid.
- `pcpi_insn` in 32: PCPI instruction word.
- `pcpi_rs1` in 32: rs1 operand.
- `pcpi_rs2` in 32: rs2 operand (unused, kept for PCPI completeness).
- `pcpi_wr` out 1: write rd. Registered.
- `pcpi_rd` out 32: rd data. Registered.
- `pcpi_wait` out 1: coprocessor busy.
- `pcpi_ready` out 1: instruction complete. Registered one-cycle pulse.
- `cpu_insn_req` out 1: COP request. Registered.
- `cop_insn_ack` in 1: COP accepted the request.
- `cpu_insn_enc` out 32: captured instruction word.
- `cpu_rs1` out 32: captured rs1.
- `cop_wen` in 1: COP write enable.
- `cop_waddr` in 5: COP destination register. Ignored, because PicoRV32 decodes rd itself.
- `cop_wdata` in 32: COP write data.
- `cop_result` in 3: COP result code.
- `cop_insn_rsp` in 1: COP instruction finished.
- `cpu_insn_ack` out 1: response accepted.
- `stat_timeout` out 1: one-cycle pulse on timeout abort.
- `stat_illegal` out 1: one-cycle pulse when a response returns `RES_ILLEGAL`.

## Operation
- `opc_hit = OPC_EN[k]` for the custom-k opcode matching `pcpi_insn[6:0]`.
- **IDLE**
  - On `pcpi_valid && opc_hit`: capture `pcpi_insn`/`pcpi_rs1` into `cpu_insn_enc`/`cpu_rs1` and go to ISSUE.
  - Non-matching instructions are ignored; `pcpi_wait` stays 0 for them.
- **ISSUE**
  - `cpu_insn_req` = 1, held until `cop_insn_ack`, then go to EXEC.
  - No timeout applies in ISSUE; the COP must ack.
  - If `pcpi_valid` falls, still hold req until ack, then go to DRAIN.
- **EXEC**
  - `cpu_insn_ack` = 1. The timeout counter increments each cycle.
  - On `cop_insn_rsp`:
    - if `cop_result != RES_ILLEGAL`: register `pcpi_wr <= cop_wen` and `pcpi_rd <= cop_wdata`, then go to RESP;
    - otherwise pulse `stat_illegal` and go to DRAIN.
  - On `pcpi_valid` low without a response: go to DRAIN.
  - On counter == `TIMEOUT` (nonzero) without a response: pulse `stat_timeout` and go to DRAIN.
- **RESP**
  - `pcpi_ready` is high in the first cycle of RESP only.
  - Stay until `pcpi_valid` is low, then go to IDLE. This prevents re-issuing the same instruction.
- **DRAIN**
  - `cpu_insn_ack` = 1. Discard the response and do not assert `pcpi_ready`.
  - Leave for IDLE once a response has been seen (a sticky flag, set on entry if it came from a response) and `pcpi_valid` is low.
  - A DRAIN entered by timeout always waits for `cop_insn_rsp`.
- **pcpi_wait** (combinational) = `pcpi_valid && opc_hit && state in {IDLE, ISSUE, EXEC}`.
  - Drops on timeout or illegal result, so PicoRV32 raises an illegal-instruction trap after its own 16-cycle PCPI timeout.
- The timeout counter clears on EXEC entry and saturates at `TIMEOUT`.

## Timing
- Reset values: all outputs 0, state IDLE, capture registers 0, counter 0.
- Reset mid-operation returns to IDLE next cycle and drops `cpu_insn_req` immediately. The COP shares `g_reset`.
- Minimum latency, `pcpi_valid` rising to `pcpi_ready`, with 0-cycle ack and 0-cycle rsp:
  - cycle 0: valid sampled;
  - cycle 1: req high, ack;
  - cycle 2: EXEC, rsp;
  - cycle 3: `pcpi_ready` = 1.
- `pcpi_wr` and `pcpi_rd` are valid only while `pcpi_ready` is high; both are cleared on leaving RESP.
- Same-cycle `cop_insn_rsp` and timeout: the response wins.
- Same-cycle `cop_insn_rsp` and `pcpi_valid` falling: go to DRAIN, response discarded.
- `cpu_insn_req` never falls before `cop_insn_ack`, except on reset.

## Structure
- Package `scarv_integ_pkg`:
  - `RES_ILLEGAL` = 3'b010;
  - the four custom opcode constants;
  - the state encoding (IDLE, ISSUE, EXEC, RESP, DRAIN, 3-bit).
- Single module, no sub-modules. The opcode match is a local function.

## Test plan
- **Normal instruction:** insn 0x0000000B, rs1 0xDEADBEEF, ack after 2 cycles, rsp after 3 cycles with wen=1, wdata 0x12345678, result 0.
  - Expect `cpu_insn_enc`/`cpu_rs1` captured.
  - Expect `pcpi_ready` one pulse with `pcpi_wr` = 1, `pcpi_rd` = 0x12345678.
- **Opcode filter:** `OPC_EN` = 4'b0001, insn opcode 7'b0101011.
  - Expect `cpu_insn_req` and `pcpi_wait` to stay 0.
- **Illegal result:** rsp with result 3'b010.
  - Expect no `pcpi_ready`, `stat_illegal` pulse, `pcpi_wait` 0 next cycle.
  - Expect IDLE after `pcpi_valid` drops.
- **Timeout:** `TIMEOUT` = 4, COP never responds.
  - Expect `stat_timeout` on the 5th EXEC cycle and `pcpi_wait` falls.
  - Late rsp is discarded, then IDLE.
- **Abort:** `pcpi_valid` drops in EXEC.
  - Expect DRAIN, response swallowed, no `pcpi_ready`.
- **Reset:** `g_reset` asserted in ISSUE with req high.
  - Expect req 0 and state IDLE the next cycle.
